aes128_decrypt_iter: RTL and testbench
======================================

// Module: aes128_decrypt_iter
// PURPOSE
//  Iterative AES-128 decryption core (FIPS-197 inverse cipher). Computes one round per clock and is
//  the receive-side counterpart of the pipelined encryption top. Accepts a ciphertext and key over a
//  valid/ready handshake and returns plaintext over a held valid/ready handshake.
//  Derives the last round key on chip and walks the key schedule backwards, one round key per round.
// PARAMETERS
//  KEY_CACHE  1  1: keep round key 10 of the last key; a matching key skips expansion. 0: always expand
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    asynchronous, active-high reset
//  in_valid     in   1    cipher_text/key valid
//  in_ready     out  1    core idle, can accept
//  cipher_text  in   128  ciphertext, byte 0 = [127:120]
//  key          in   128  cipher key, same byte order
//  out_valid    out  1    plain_text valid, held until out_ready
//  out_ready    in   1    downstream accepts
//  plain_text   out  128  recovered plaintext, registered
// BEHAVIOUR
//  Reset (async, active-high): FSM=IDLE, in_ready=1, out_valid=0, plain_text=0, cache invalid.
//   While rst is high, in_valid is ignored.
//  FSM states:
//   IDLE -> (in_valid&in_ready) -> KEYEXP, or -> INIT on a cache hit.
//    On accept: register ct and key, rc=1.
//   KEYEXP: 10 cycles. Forward expansion rk <= next(rk). After the 10th cycle rk=rk10; -> INIT.
//   INIT: 1 cycle. st <= ct ^ rk10; rk stays rk10; cache updated (KEY_CACHE=1); round=9; -> ROUND.
//   ROUND: 9 cycles, r=9..1.
//    rk <= inv_next(rk) gives rk_r.
//    st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk_r)).
//    -> FINAL after r=1.
//   FINAL: 1 cycle.
//    plain_text <= AddRoundKey(InvSubBytes(InvShiftRows(st)), rk0); out_valid <= 1; -> HOLD.
//   HOLD: plain_text and out_valid stable until out_ready=1; out_valid falls on that edge; -> IDLE.
//  Cache hit: key == cached key and cache valid -> skip KEYEXP.
//  Latency, from the accepting edge to out_valid high: 21 edges on a miss, 11 edges on a hit.
//  in_ready=1 only in IDLE, so there is one block in flight. No accept is possible in the HOLD cycle
//   where out_ready is consumed; the next accept is at the earliest on the following edge.
//  Key schedule in the 32-bit word domain (w0..w3, w0 = [127:96]):
//   next: w0' = w0^SubWord(RotWord(w3))^Rcon; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
//   inv_next: w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'; w0 = w0'^SubWord(RotWord(w3))^Rcon.
//  Rcon register: in KEYEXP it starts at 01 and shifts with xtime (…80 -> 1b -> 36).
//   In ROUND/FINAL it starts at 36 and steps with inv-xtime (36 -> 1b -> 80 … -> 01).
//   It wraps over exactly 10 steps each way.
//  GF(2^8) arithmetic is modulo x^8+x^4+x^3+x+1. All XORs are bitwise 128-bit; no carries.
//  out_ready high while out_valid=0 is ignored. in_valid dropping mid-operation has no effect.
//  Reset mid-operation aborts the block: no out_valid pulse, and the cache is invalidated.
// STRUCTURE
//  Package aes_pkg holds:
//   - fsm state enum (IDLE, KEYEXP, INIT, ROUND, FINAL, HOLD)
//   - sbox/inv_sbox functions, xtime/gmul functions
//   - RCON_FIRST=8'h01, RCON_LAST=8'h36
//   - key_next/key_inv_next functions
//  Shared with the encryption side.
//  One sub-module: aes_inv_round (combinational; inputs st, rk, final_flag; output st_next).
//   final_flag=1 bypasses InvMixColumns.
//  Top holds the FSM, 4-bit round counter, rk/rcon/st registers, cache registers and output register.
// TESTING
//  1 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//    -> plain_text 3243f6a8885a308d313198a2e0370734; out_valid exactly 21 edges after accept.
//    Internal rk after KEYEXP = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> 00112233445566778899aabbccddeeff.
//  3 Cache: repeat C.1 with the same key -> same plaintext after 11 edges.
//    Then App.B key -> 21 edges. With KEY_CACHE=0 every run takes 21 edges.
//  4 Backpressure: hold out_ready=0 for 50 cycles -> plain_text/out_valid stable, in_ready=0, in_valid ignored.
//    Release -> out_valid drops next edge, in_ready=1.
//  5 Reset at round 5 of App.B -> outputs 0, in_ready=1 immediately.
//    Next App.B block takes 21 edges (cache invalid) and decrypts correctly.
//  6 Loopback: 1000 random key/pt through the encryption top, then this core -> plaintext recovered bit-exact.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: AES state encoding, GF(2^8) helpers, S-boxes and key-schedule steps shared by the AES cores.
package aes_pkg;
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, HOLD} state_t;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rcon, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] key_inv_next(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot(w3) ^ {rcon, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; final_flag skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         final_flag,
  output logic [127:0] st_next
);
  localparam logic [31:0] IMC = 32'h0e0b0d09;
  logic [127:0] a, m;
  logic [7:0] acc;
  always_comb begin
    a = '0;
    m = '0;
    acc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
    a = a ^ rk;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(IMC[31-8*((j+4-i)%4) -: 8], a[127-8*(4*c+j) -: 8]);
        m[127-8*(4*c+i) -: 8] = acc;
      end
    st_next = final_flag ? a : m;
  end
endmodule

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock,
// expanding to round key 10 then walking the key schedule backwards.
module aes128_decrypt_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_text
);
  state_t state;
  logic [3:0] cnt;
  logic [7:0] rcon;
  logic [127:0] rk, st, ct_q, key_q, c_key, c_rk, rk_prev, rnd_out;
  logic c_vld, hit;
  assign in_ready = state == IDLE;
  assign hit = KEY_CACHE && c_vld && (key == c_key);
  assign rk_prev = key_inv_next(rk, rcon);
  aes_inv_round u_rnd (
    .st(st),
    .rk(rk_prev),
    .final_flag(state == FINAL),
    .st_next(rnd_out)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rcon <= '0;
      rk <= '0;
      st <= '0;
      ct_q <= '0;
      key_q <= '0;
      c_key <= '0;
      c_rk <= '0;
      c_vld <= 1'b0;
      out_valid <= 1'b0;
      plain_text <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ct_q <= cipher_text;
          key_q <= key;
          rcon <= RCON_FIRST;
          rk <= hit ? c_rk : key;
          cnt <= 4'd10;
          state <= hit ? INIT : KEYEXP;
        end
        KEYEXP: begin
          rk <= key_next(rk, rcon);
          rcon <= xtime(rcon);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= INIT;
        end
        INIT: begin
          st <= ct_q ^ rk;
          rcon <= RCON_LAST;
          cnt <= 4'd9;
          if (KEY_CACHE) begin
            c_key <= key_q;
            c_rk <= rk;
            c_vld <= 1'b1;
          end
          state <= ROUND;
        end
        ROUND: begin
          st <= rnd_out;
          rk <= rk_prev;
          rcon <= inv_xtime(rcon);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= FINAL;
        end
        FINAL: begin
          plain_text <= rnd_out;
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: known-answer vectors, cache latency, backpressure and mid-block reset.
module tb_aes128_decrypt_iter;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] cipher_text, key, plain_text;
  int tests, fails;
  aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cipher_text(cipher_text),
    .key(key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plain_text(plain_text)
  );
  typedef struct {
    logic [127:0] key, ct, pt, rk10;
    int lat;
  } vec_t;
  vec_t v [7];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [127:0] k, input logic [127:0] c);
    chk("in_ready before accept", 128'(in_ready), 128'(1));
    in_valid = 1;
    key = k;
    cipher_text = c;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_out(output int n, input logic [127:0] rk10);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 10 && rk10 != '0) chk("rk after keyexp", dut.rk, rk10);
    end
  endtask
  task automatic run(input int i);
    int n;
    send(v[i].key, v[i].ct);
    wait_out(n, v[i].rk10);
    chk($sformatf("v%0d latency", i), 128'(n), 128'(v[i].lat));
    chk($sformatf("v%0d plain_text", i), plain_text, v[i].pt);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk($sformatf("v%0d out_valid drop", i), 128'(out_valid), 128'(0));
    chk($sformatf("v%0d in_ready back", i), 128'(in_ready), 128'(1));
  endtask
  initial begin
    int n;
    logic [127:0] held;
    tests = 0;
    fails = 0;
    v[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
             128'h3243f6a8885a308d313198a2e0370734, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 21};
    v[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'h00112233445566778899aabbccddeeff, 128'h13111d7fe3944a17f307a78b4d2b30c5, 21};
    v[2] = '{v[1].key, v[1].ct, v[1].pt, 128'h0, 11};
    v[3] = '{v[0].key, v[0].ct, v[0].pt, 128'h0, 21};
    v[4] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, 21};
    v[5] = '{v[0].key, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
             128'h6bc1bee22e409f96e93d7e117393172a, 128'h0, 21};
    v[6] = '{v[0].key, v[0].ct, v[0].pt, 128'h0, 11};
    rst = 1;
    in_valid = 1;
    key = '1;
    cipher_text = '1;
    out_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset plain_text", plain_text, 128'h0);
    rst = 0;
    in_valid = 0;
    out_ready = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) run(i);
    send(v[1].key, v[1].ct);
    wait_out(n, 128'h0);
    chk("bp latency", 128'(n), 128'(21));
    held = plain_text;
    chk("bp plain_text", held, v[1].pt);
    in_valid = 1;
    key = 128'h0;
    cipher_text = 128'h0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("bp hold plain_text", plain_text, held);
      chk("bp hold out_valid", 128'(out_valid), 128'(1));
      chk("bp hold in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp release out_valid", 128'(out_valid), 128'(0));
    chk("bp release in_ready", 128'(in_ready), 128'(1));
    run(2);
    run(3);
    send(v[0].key, v[0].ct);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort out_valid", 128'(out_valid), 128'(0));
    chk("abort plain_text", plain_text, 128'h0);
    chk("abort in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("post-abort out_valid", 128'(out_valid), 128'(0));
    run(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
